// File: rtl/fifo_read_ctrl_fwft.sv
// fifo_read_ctrl_fwft
// Read-domain controller for the async FIFO. Owns the binary/Gray read
// pointer, the registered empty flag, occupancy count, almost-empty and sticky
// underflow flags, and an optional first-word-fall-through output register.
// The RAM read port is combinational on read_address.

`timescale 1ns/1ps

module fifo_read_ctrl_fwft #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int FWFT     = 0,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             read_clock,
  input  logic             read_reset_n,
  input  logic             read_enable,
  input  logic             underflow_clear,
  input  logic [AW:0]      sync_write_pointer,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic [AW-1:0]    read_address,
  output logic [AW:0]      read_pointer,
  output logic             fifo_empty,
  output logic             almost_empty,
  output logic [AW:0]      read_count,
  output logic             underflow,
  output logic [WIDTH-1:0] read_data,
  output logic             data_valid
);

  localparam bit          FWFT_EN = (FWFT != 0);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_LEVEL);

  // Binary to reflected-Gray conversion.
  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Reflected-Gray to binary conversion (prefix XOR from the MSB down).
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // State registers and their next-state values
  logic [AW:0]      bin_q, bin_d;
  logic [AW:0]      gray_q, gray_d;
  logic             mem_empty_q, mem_empty_d;
  logic             dv_q, dv_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [AW:0]      count_q, count_d;
  logic             ae_q, ae_d;
  logic             uf_q, uf_d;

  // Combinational helpers
  logic             pop_s;
  logic             fifo_empty_s;
  logic [AW:0]      wbin_s;
  logic [AW:0]      mem_words_s;

  // Memory pointer advance: in FWFT mode the head word is prefetched whenever
  // the output register is free or is being consumed this cycle.
  always_comb begin
    pop_s = 1'b0;
    if (FWFT_EN) begin
      pop_s = ~mem_empty_q & (~dv_q | read_enable);
    end else begin
      pop_s = read_enable & ~mem_empty_q;
    end
  end

  // Consumer-visible empty: the output register in FWFT mode, the RAM otherwise.
  always_comb begin
    fifo_empty_s = 1'b1;
    if (FWFT_EN) begin
      fifo_empty_s = ~dv_q;
    end else begin
      fifo_empty_s = mem_empty_q;
    end
  end

  // Next read pointer in binary and Gray; the Gray form goes to the write side.
  always_comb begin
    bin_d       = bin_q + {{AW{1'b0}}, pop_s};
    gray_d      = bin2gray(bin_d);
    mem_empty_d = (gray_d == sync_write_pointer);
  end

  // FWFT output stage: load on pop, drop on consumption, otherwise hold.
  always_comb begin
    dv_d    = dv_q;
    rdata_d = rdata_q;
    if (!FWFT_EN) begin
      dv_d    = 1'b0;
      rdata_d = rdata_q;
    end else if (pop_s) begin
      dv_d    = 1'b1;
      rdata_d = mem_read_data;
    end else if (read_enable && dv_q) begin
      dv_d    = 1'b0;
    end else begin
      dv_d    = dv_q;
      rdata_d = rdata_q;
    end
  end

  // Occupancy against the synchronised (lagging) write pointer, so the count
  // can only under-report; the output register counts as a held word.
  always_comb begin
    wbin_s      = gray2bin(sync_write_pointer);
    mem_words_s = wbin_s - bin_d;
    count_d     = mem_words_s + {{AW{1'b0}}, dv_d};
    ae_d        = (count_d <= AE_LVL);
  end

  // Sticky underflow: a read attempt while empty wins over a coincident clear.
  always_comb begin
    uf_d = uf_q;
    if (read_enable && fifo_empty_s) begin
      uf_d = 1'b1;
    end else if (underflow_clear) begin
      uf_d = 1'b0;
    end else begin
      uf_d = uf_q;
    end
  end

  // Register all read-domain state; asynchronous reset to the empty FIFO.
  always_ff @(posedge read_clock or negedge read_reset_n) begin
    if (!read_reset_n) begin
      bin_q       <= {(AW+1){1'b0}};
      gray_q      <= {(AW+1){1'b0}};
      mem_empty_q <= 1'b1;
      dv_q        <= 1'b0;
      rdata_q     <= {WIDTH{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      ae_q        <= 1'b1;
      uf_q        <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      mem_empty_q <= mem_empty_d;
      dv_q        <= dv_d;
      rdata_q     <= rdata_d;
      count_q     <= count_d;
      ae_q        <= ae_d;
      uf_q        <= uf_d;
    end
  end

  assign read_address = bin_q[AW-1:0];
  assign read_pointer = gray_q;
  assign fifo_empty   = fifo_empty_s;
  assign almost_empty = ae_q;
  assign read_count   = count_q;
  assign underflow    = uf_q;
  // Standard mode passes the RAM word straight through.
  assign read_data    = FWFT_EN ? rdata_q : mem_read_data;
  assign data_valid   = FWFT_EN ? dv_q : ~mem_empty_q;

endmodule

// File: tb/tb_fifo_read_ctrl_fwft.sv
// Bench for fifo_read_ctrl_fwft: one standard-mode and one FWFT instance run
// side by side. A word-level reference (write/pop counts and the output-register
// occupancy) predicts flags and pointers; a scoreboard queue of written words is
// compared by a separate monitor whenever the consumer takes a word.

`timescale 1ns/1ps

module tb_fifo_read_ctrl_fwft;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int AEL   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic             re [2];
  logic             clr [2];
  logic [AW:0]      wp [2];
  logic [WIDTH-1:0] mrd [2];
  logic [AW-1:0]    raddr [2];
  logic [AW:0]      rptr [2];
  logic             empty [2];
  logic             ae [2];
  logic [AW:0]      cnt [2];
  logic             uf [2];
  logic [WIDTH-1:0] rdata [2];
  logic             dv [2];

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];

  // Reference state (index 0: standard, 1: FWFT)
  int          wcnt [2];
  int          popped [2];
  int          avail [2];
  bit          ov [2];
  bit          ufm [2];
  logic [AW:0] prev_rp [2];
  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mrd[0] = mem0[raddr[0]];
  assign mrd[1] = mem1[raddr[1]];

  fifo_read_ctrl_fwft #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AE_LEVEL(AEL)) u_std (
    .read_clock(clk), .read_reset_n(rst_n), .read_enable(re[0]),
    .underflow_clear(clr[0]), .sync_write_pointer(wp[0]), .mem_read_data(mrd[0]),
    .read_address(raddr[0]), .read_pointer(rptr[0]), .fifo_empty(empty[0]),
    .almost_empty(ae[0]), .read_count(cnt[0]), .underflow(uf[0]),
    .read_data(rdata[0]), .data_valid(dv[0]));

  fifo_read_ctrl_fwft #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AE_LEVEL(AEL)) u_fwft (
    .read_clock(clk), .read_reset_n(rst_n), .read_enable(re[1]),
    .underflow_clear(clr[1]), .sync_write_pointer(wp[1]), .mem_read_data(mrd[1]),
    .read_address(raddr[1]), .read_pointer(rptr[1]), .fifo_empty(empty[1]),
    .almost_empty(ae[1]), .read_count(cnt[1]), .underflow(uf[1]),
    .read_data(rdata[1]), .data_valid(dv[1]));

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h", name, m, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      wcnt[m] = 0; popped[m] = 0; avail[m] = 0;
      ov[m] = 1'b0; ufm[m] = 1'b0; prev_rp[m] = '0;
      wp[m] = '0; re[m] = 1'b0; clr[m] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_reset();
    for (int m = 0; m < 2; m++) begin
      chk("rst_empty", m, empty[m], 1);
      chk("rst_ae", m, ae[m], 1);
      chk("rst_count", m, cnt[m], 0);
      chk("rst_uf", m, uf[m], 0);
      chk("rst_valid", m, dv[m], 0);
      chk("rst_raddr", m, raddr[m], 0);
      chk("rst_rptr", m, rptr[m], 0);
    end
    chk("rst_rdata", 1, rdata[1], 0);
  endtask

  // Producer: place one word in RAM and publish the new Gray write pointer,
  // never exceeding DEPTH words held by the consumer side.
  task automatic write_word(input int m);
    logic [WIDTH-1:0] d;
    if (wcnt[m] - popped[m] + int'(ov[m]) < DEPTH) begin
      d = WIDTH'($urandom);
      if (m == 0) begin
        mem0[wcnt[m] % DEPTH] = d;
        q0.push_back(d);
      end else begin
        mem1[wcnt[m] % DEPTH] = d;
        q1.push_back(d);
      end
      wcnt[m]++;
      wp[m] = to_gray(wcnt[m]);
    end
  endtask

  // One clock: advance the reference at the edge, then check all outputs.
  task automatic step();
    bit was_empty [2];
    bit pop [2];
    int cexp;
    for (int m = 0; m < 2; m++) was_empty[m] = (m == 1) ? !ov[m] : (avail[m] == 0);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      pop[m] = (avail[m] > 0) && ((m == 0) ? re[m] : (!ov[m] || re[m]));
      if (m == 1) begin
        if (pop[m]) ov[m] = 1'b1;
        else if (re[m] && ov[m]) ov[m] = 1'b0;
      end
      if (re[m] && was_empty[m]) ufm[m] = 1'b1;
      else if (clr[m]) ufm[m] = 1'b0;
      popped[m] += int'(pop[m]);
      avail[m] = wcnt[m] - popped[m];
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      re[m] = 1'b0;
      clr[m] = 1'b0;
      cexp = avail[m] + ((m == 1) ? int'(ov[m]) : 0);
      chk("empty", m, empty[m], (m == 1) ? !ov[m] : (avail[m] == 0));
      chk("valid", m, dv[m], (m == 1) ? ov[m] : (avail[m] != 0));
      chk("count", m, cnt[m], cexp);
      chk("almost_empty", m, ae[m], cexp <= AEL);
      chk("underflow", m, uf[m], ufm[m]);
      chk("raddr", m, raddr[m], popped[m] % DEPTH);
      chk("rptr", m, rptr[m], to_gray(popped[m]));
      chk("gray_step", m, $countones(rptr[m] ^ prev_rp[m]), int'(pop[m]));
      prev_rp[m] = rptr[m];
    end
  endtask

  // Monitor: a consumed word must be the oldest word written.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        if (re[m] && !empty[m]) begin
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            chk("sb_word_expected", m, 0, 1);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk("rdata", m, rdata[m], e);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Three words, then three reads plus one read while empty.
    for (int k = 0; k < 3; k++) begin
      write_word(0);
      write_word(1);
    end
    step();
    chk("tp_count3", 0, cnt[0], 3);
    chk("tp_empty_low", 0, empty[0], 0);
    step();
    for (int k = 0; k < 4; k++) begin
      re[0] = 1'b1;
      re[1] = 1'b1;
      step();
    end
    chk("tp_rptr", 0, rptr[0], 5'b00010);
    chk("tp_uf_set", 0, uf[0], 1);
    chk("tp_uf_set", 1, uf[1], 1);

    // Clear, then coincident set and clear, then clear again.
    clr[0] = 1'b1; clr[1] = 1'b1;
    step();
    re[0] = 1'b1; re[1] = 1'b1; clr[0] = 1'b1; clr[1] = 1'b1;
    step();
    chk("tp_uf_set_wins", 1, uf[1], 1);
    clr[0] = 1'b1; clr[1] = 1'b1;
    step();

    // Fill to full depth, then drain past the almost-empty threshold.
    for (int k = 0; k < DEPTH; k++) begin
      write_word(0);
      write_word(1);
      step();
    end
    step();
    chk("tp_full_count", 0, cnt[0], DEPTH);
    chk("tp_full_count", 1, cnt[1], DEPTH);
    for (int k = 0; k < DEPTH + 2; k++) begin
      re[0] = 1'b1;
      re[1] = 1'b1;
      step();
    end

    // Randomised traffic with many pointer wraps.
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 99) < 50) write_word(m);
        re[m]  = ($urandom_range(0, 99) < 48);
        clr[m] = ($urandom_range(0, 99) < 5);
      end
      step();
    end

    // Drain the outputs, load five words, then reset mid-stream.
    for (int k = 0; k < DEPTH + 4; k++) begin
      re[0] = 1'b1; re[1] = 1'b1; clr[0] = 1'b1; clr[1] = 1'b1;
      step();
    end
    for (int k = 0; k < 5; k++) begin
      write_word(0);
      write_word(1);
    end
    repeat (3) step();
    chk("tp_pre_reset_count", 0, cnt[0], 5);
    chk("tp_pre_reset_count", 1, cnt[1], 5);
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 99) < 50) write_word(m);
        re[m]  = ($urandom_range(0, 99) < 45);
        clr[m] = ($urandom_range(0, 99) < 5);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
